mem_controller: RTL and testbench
=================================

# mem_controller

Sequences the single byte-wide RAM port between the LoadStoreBuffer and instruction fetch. It arbitrates requests and splits each access into per-byte RAM cycles. Load data is reassembled and sign- or zero-extended; store data is serialized. Each requester receives a one-cycle ready pulse with its result. The block sits between the core (LSB, IFetch) and the top-level RAM/IO bus.

## Interface
- No parameters.
- clk_in  in  1  system clock; all state on posedge
- rst_in  in  1  asynchronous, active-high reset
- rdy_in  in  1  low = freeze all state; mem_wr forced 0
- rob_clear  in  1  pipeline flush
- lsb_valid  in  1  LSB request; held until lsb_ready
- lsb_wr  in  1  1 = store
- lsb_len  in  3  [1:0] size log2 (0=B,1=H,2=W); [2] unsigned load
- lsb_addr  in  32  byte address
- lsb_value  in  32  store data, little-endian
- lsb_ready  out  1  one-cycle completion pulse (load and store)
- lsb_result  out  32  extended load data; valid with lsb_ready
- if_valid  in  1  fetch request; held until if_ready
- if_addr  in  32  fetch address
- if_ready  out  1  one-cycle completion pulse
- if_inst  out  32  fetched word; valid with if_ready
- mem_din  in  8  RAM read byte; returns the cycle after mem_a
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write this cycle
- io_buffer_full  in  1  IO write buffer full

## Operation
- States: IDLE, LOAD, STORE, DONE. Reset: IDLE, all outputs 0.
- Requests are sampled only in IDLE.
- Grant in IDLE: fixed priority, LSB over IF (see Configuration).
- On grant, latch addr, len, value, owner, then go to LOAD or STORE. IF is always a 4-byte load.
- Byte count is n = 1 << len[1:0]. Byte addresses are addr+k, k=0..n-1, mod 2^32. Misaligned addresses are allowed.
- LOAD: drive mem_a = addr+k on n consecutive cycles. Capture mem_din one cycle later into byte lane k. After the last byte, go to DONE.
- Load extension: len[2]=0 sign-extends from bit 8n-1; len[2]=1 zero-extends. Word loads ignore len[2].
- STORE: mem_wr=1, mem_a=addr+k, mem_dout=value[8k+7:8k] on each cycle. After byte n-1, go to DONE.
- IO stall: if io_buffer_full=1 and addr+k has [17:16]==2'b11, drive mem_wr=0 and do not advance k.
- DONE: pulse the owner's ready with the result for one cycle, then return to IDLE. No request is accepted in DONE.
- rob_clear during LOAD or fetch: abort to IDLE, no ready pulse, no pending bytes consumed.
- rob_clear during STORE: finish all bytes so memory stays consistent, but suppress lsb_ready.
- rob_clear in IDLE: no grant that cycle.
- Outside LOAD/STORE: mem_wr=0, mem_a=0, mem_dout=0.

## Timing
- Request seen in IDLE at cycle t.
- Load of n bytes: mem_a at t+1..t+n, data at t+2..t+n+1, ready at t+n+2. Word load or fetch: ready at t+6.
- Store of n bytes: writes at t+1..t+n, ready at t+n+1 (plus IO stall cycles). Word store: ready at t+5.
- Next grant is possible at t+n+3 (load) or t+n+2 (store).
- lsb_result and if_inst are registered. They hold their value after ready until the next completion.
- rdy_in low at any cycle: counter, state and captured bytes hold; mem_wr=0. On resume, the cycle repeats.
- rst_in asserted mid-access: immediate IDLE and zeroed outputs. A partial store is left as written.

## Configuration
- MEM_CTRL_RR_ARB_EN defined: round-robin arbitration. When both requesters are valid in IDLE, grant the one not granted last. The last-grant register resets to IF, so LSB wins the first tie.
- Undefined: fixed LSB-over-IF priority.

## Structure
- config.v holds: length encodings (LEN_B/H/W, unsigned bit), IO region match bits [17:16]==2'b11, state encodings.
- Optional sub-module mem_ctrl_arb: two-requester grant logic, plus the last-grant register when MEM_CTRL_RR_ARB_EN is set.

## Test plan
- IF fetch of 0x1000, RAM bytes 13 05 00 00: if_ready at t+6 with if_inst=0x00000513; mem_a=0x1000..0x1003.
- LSB lb at 0x2001 (byte 0x80): lsb_result=0xFFFFFF80. lbu gives 0x00000080. lh at 0x2000 (bytes 34 80) gives 0xFFFF8034.
- LSB sw 0xDEADBEEF to 0x3000: writes EF,BE,AD,DE at t+1..t+4, lsb_ready at t+5, no if_ready.
- sb to 0x30000 with io_buffer_full high for 3 cycles: mem_wr stays 0 for those 3 cycles, then one write; lsb_ready delayed by 3.
- Both requesters valid in IDLE: LSB granted. With MEM_CTRL_RR_ARB_EN, back-to-back requests alternate grants LSB, IF, LSB.
- rob_clear at t+3 of a fetch: no if_ready, IDLE at t+4. rob_clear mid-sw: all 4 bytes written, lsb_ready suppressed.

Source files
------------

// File: rtl/mem_controller_pkg.sv
// mem_controller_pkg: shared encodings for the byte-wide RAM port sequencer.
//   - FSM state encodings (ST_*)
//   - access length encodings (LEN_B/H/W) and the unsigned-load bit position
//   - IO region match value for address bits [17:16]
//   - helpers: byte_count() and extend_load()
package mem_controller_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_STORE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd2;
    localparam int unsigned LEN_UNSIGNED_BIT = 2;

    // Writes whose byte address has [17:16] equal to this go to the IO buffer.
    localparam logic [1:0] IO_REGION = 2'b11;

    // Number of RAM byte cycles for a size code; the unused code 3 is treated as a word.
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            LEN_B:   byte_count = 3'd1;
            LEN_H:   byte_count = 3'd2;
            default: byte_count = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [2:0] len);
        logic zext;
        zext = len[LEN_UNSIGNED_BIT];
        case (len[1:0])
            LEN_B:   extend_load = zext ? {24'd0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
            LEN_H:   extend_load = zext ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: extend_load = raw;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// mem_ctrl_arb: two-requester grant logic for the RAM port.
//   en       in   grant window (controller idle, not frozen, no flush)
//   req_lsb  in   LoadStoreBuffer request
//   req_if   in   instruction fetch request
//   gnt_lsb  out  LSB granted this cycle
//   gnt_if   out  IF granted this cycle
// Macro MEM_CTRL_RR_ARB_EN: round-robin on ties (adds clk_in/rst_in and a
// last-grant register); otherwise fixed LSB-over-IF priority.
module mem_ctrl_arb (
`ifdef MEM_CTRL_RR_ARB_EN
    input  logic clk_in,
    input  logic rst_in,
`endif
    input  logic en,
    input  logic req_lsb,
    input  logic req_if,
    output logic gnt_lsb,
    output logic gnt_if
);

`ifdef MEM_CTRL_RR_ARB_EN
    // Resets to IF so the first tie goes to the LSB.
    logic last_if_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            last_if_q <= 1'b1;
        end else if (gnt_lsb) begin
            last_if_q <= 1'b0;
        end else if (gnt_if) begin
            last_if_q <= 1'b1;
        end
    end

    always_comb begin
        gnt_lsb = en && req_lsb && !(req_if && !last_if_q);
        gnt_if  = en && req_if && !gnt_lsb;
    end
`else
    always_comb begin
        gnt_lsb = en && req_lsb;
        gnt_if  = en && req_if && !req_lsb;
    end
`endif

endmodule

// File: rtl/mem_controller.sv
// mem_controller: sequences the byte-wide RAM port between the LSB and IFetch.
// Each granted access is split into 1/2/4 byte cycles; loads are reassembled
// and extended, stores serialized. Owners get a one-cycle ready pulse.
//   clk_in, rst_in (async, active-high), rdy_in (low = freeze), rob_clear (flush)
//   lsb_valid/wr/len/addr/value -> lsb_ready, lsb_result
//   if_valid/if_addr            -> if_ready, if_inst
//   mem_din (one cycle after mem_a), mem_dout, mem_a, mem_wr, io_buffer_full
// Macro MEM_CTRL_RR_ARB_EN selects round-robin arbitration (default: LSB first).
module mem_controller
    import mem_controller_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear,
    input  logic        lsb_valid,
    input  logic        lsb_wr,
    input  logic [2:0]  lsb_len,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_value,
    output logic        lsb_ready,
    output logic [31:0] lsb_result,
    input  logic        if_valid,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_inst,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    logic [1:0]       state_q;
    logic [2:0]       cnt_q;
    logic [31:0]      addr_q;
    logic [2:0]       len_q;
    logic [31:0]      value_q;
    logic             owner_if_q;
    logic             flush_q;
    logic [3:0][7:0]  buf_q;

    logic [2:0]       n_bytes;
    logic [2:0]       prev_cnt;
    logic [2:0]       ld_off;
    logic [31:0]      cur_a;
    logic             io_stall;
    logic [3:0][7:0]  asm_bytes;
    logic             arb_en;
    logic             gnt_lsb;
    logic             gnt_if;

    assign arb_en = (state_q == ST_IDLE) && rdy_in && !rob_clear;

    mem_ctrl_arb u_arb (
`ifdef MEM_CTRL_RR_ARB_EN
        .clk_in  (clk_in),
        .rst_in  (rst_in),
`endif
        .en      (arb_en),
        .req_lsb (lsb_valid),
        .req_if  (if_valid),
        .gnt_lsb (gnt_lsb),
        .gnt_if  (gnt_if)
    );

    always_comb begin
        n_bytes  = byte_count(len_q[1:0]);
        prev_cnt = cnt_q - 3'd1;
        cur_a    = addr_q + {29'd0, cnt_q};
        io_stall = io_buffer_full && (cur_a[17:16] == IO_REGION);
        // While frozen mid-load, re-present the previous address so mem_din
        // still carries the byte that will be captured when the cycle repeats.
        ld_off   = (!rdy_in && (cnt_q != 3'd0)) ? prev_cnt : cnt_q;
        // Byte lanes including the one arriving on mem_din this cycle.
        asm_bytes = buf_q;
        if (cnt_q != 3'd0) begin
            asm_bytes[prev_cnt[1:0]] = mem_din;
        end
    end

    always_comb begin
        mem_a    = 32'd0;
        mem_dout = 8'd0;
        mem_wr   = 1'b0;
        if (state_q == ST_LOAD) begin
            if (ld_off < n_bytes) begin
                mem_a = addr_q + {29'd0, ld_off};
            end
        end else if (state_q == ST_STORE) begin
            mem_a    = cur_a;
            mem_dout = value_q[{cnt_q[1:0], 3'b000} +: 8];
            mem_wr   = rdy_in && !io_stall;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            addr_q     <= 32'd0;
            len_q      <= 3'd0;
            value_q    <= 32'd0;
            owner_if_q <= 1'b0;
            flush_q    <= 1'b0;
            buf_q      <= '0;
            lsb_ready  <= 1'b0;
            lsb_result <= 32'd0;
            if_ready   <= 1'b0;
            if_inst    <= 32'd0;
        end else if (rdy_in) begin
            lsb_ready <= 1'b0;
            if_ready  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q   <= 3'd0;
                    flush_q <= 1'b0;
                    buf_q   <= '0;
                    if (gnt_lsb) begin
                        addr_q     <= lsb_addr;
                        len_q      <= lsb_len;
                        value_q    <= lsb_value;
                        owner_if_q <= 1'b0;
                        state_q    <= lsb_wr ? ST_STORE : ST_LOAD;
                    end else if (gnt_if) begin
                        addr_q     <= if_addr;
                        len_q      <= {1'b0, LEN_W};
                        value_q    <= 32'd0;
                        owner_if_q <= 1'b1;
                        state_q    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (rob_clear) begin
                        state_q <= ST_IDLE;
                    end else begin
                        if (cnt_q != 3'd0) begin
                            buf_q[prev_cnt[1:0]] <= mem_din;
                        end
                        // cnt_q == n_bytes is the extra cycle that catches the last byte.
                        if (cnt_q == n_bytes) begin
                            state_q <= ST_DONE;
                            if (owner_if_q) begin
                                if_ready <= 1'b1;
                                if_inst  <= asm_bytes;
                            end else begin
                                lsb_ready  <= 1'b1;
                                lsb_result <= extend_load(asm_bytes, len_q);
                            end
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                end
                ST_STORE: begin
                    // A flushed store still drains so memory is never left half-updated.
                    if (rob_clear) begin
                        flush_q <= 1'b1;
                    end
                    if (!io_stall) begin
                        if (cnt_q == n_bytes - 3'd1) begin
                            state_q   <= ST_DONE;
                            lsb_ready <= !(flush_q || rob_clear);
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_controller.sv
// tb_mem_controller: directed-vector bench for mem_controller with a
// synchronous byte RAM model (read data one cycle after mem_a).
module tb_mem_controller;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_clear;
    logic        lsb_valid;
    logic        lsb_wr;
    logic [2:0]  lsb_len;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_value;
    logic        lsb_ready;
    logic [31:0] lsb_result;
    logic        if_valid;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    mem_controller dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .rob_clear      (rob_clear),
        .lsb_valid      (lsb_valid),
        .lsb_wr         (lsb_wr),
        .lsb_len        (lsb_len),
        .lsb_addr       (lsb_addr),
        .lsb_value      (lsb_value),
        .lsb_ready      (lsb_ready),
        .lsb_result     (lsb_result),
        .if_valid       (if_valid),
        .if_addr        (if_addr),
        .if_ready       (if_ready),
        .if_inst        (if_inst),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    logic [7:0] ram [0:262143];

    always @(posedge clk_in) begin
        if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
        mem_din <= ram[mem_a[17:0]];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Per-cycle log of one transaction; index i is cycle t+i.
    logic [31:0] log_a    [0:31];
    logic        log_wr   [0:31];
    logic [7:0]  log_dout [0:31];
    int          nwr;
    int          n_lsb;
    int          lsb_cyc  [0:3];
    logic [31:0] lsb_res  [0:3];
    int          if_cyc;
    logic [31:0] if_res;
    int          clr_at = 0;
    int          io_lo = 0;
    int          io_hi = 0;
    int          rdy_low_at = 0;
    bit          keep_lsb = 1'b0;

    task automatic lsb_req(input logic wr, input logic [2:0] len, input logic [31:0] addr,
                           input logic [31:0] val);
        @(negedge clk_in);
        lsb_valid = 1'b1;
        lsb_wr    = wr;
        lsb_len   = len;
        lsb_addr  = addr;
        lsb_value = val;
    endtask

    task automatic if_req(input logic [31:0] addr);
        @(negedge clk_in);
        if_valid = 1'b1;
        if_addr  = addr;
    endtask

    // Runs a bounded number of cycles after the request cycle t.
    task automatic run(input int max);
        nwr    = 0;
        n_lsb  = 0;
        if_cyc = 0;
        if_res = 32'd0;
        for (int k = 0; k < 4; k++) begin
            lsb_cyc[k] = 0;
            lsb_res[k] = 32'd0;
        end
        for (int i = 1; i <= max; i++) begin
            @(negedge clk_in);
            rob_clear      = (i == clr_at);
            io_buffer_full = (i >= io_lo) && (i <= io_hi);
            rdy_in         = (i != rdy_low_at);
            #1;
            log_a[i]    = mem_a;
            log_wr[i]   = mem_wr;
            log_dout[i] = mem_dout;
            if (mem_wr) nwr++;
            if (lsb_ready && n_lsb < 4) begin
                lsb_cyc[n_lsb] = i;
                lsb_res[n_lsb] = lsb_result;
                n_lsb++;
                if (!keep_lsb) lsb_valid = 1'b0;
            end
            if (if_ready && if_cyc == 0) begin
                if_cyc   = i;
                if_res   = if_inst;
                if_valid = 1'b0;
            end
            if (rob_clear || i == max) begin
                lsb_valid = 1'b0;
                if_valid  = 1'b0;
            end
        end
        rob_clear      = 1'b0;
        io_buffer_full = 1'b0;
        rdy_in         = 1'b1;
        clr_at         = 0;
        io_lo          = 0;
        io_hi          = 0;
        rdy_low_at     = 0;
        keep_lsb       = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0; io_buffer_full = 1'b0;
        lsb_valid = 1'b0; lsb_wr = 1'b0; lsb_len = 3'd0; lsb_addr = 32'd0; lsb_value = 32'd0;
        if_valid = 1'b0; if_addr = 32'd0;
        for (int a = 0; a < 262144; a++) ram[a] = 8'h00;
        ram[18'h1000] = 8'h13; ram[18'h1001] = 8'h05;
        ram[18'h2000] = 8'h34; ram[18'h2001] = 8'h80;

        repeat (2) @(negedge clk_in);
        check("rst_lsb_ready", {31'd0, lsb_ready}, 32'd0);
        check("rst_if_ready", {31'd0, if_ready}, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_lsb_result", lsb_result, 32'd0);
        check("rst_if_inst", if_inst, 32'd0);
        rst_in = 1'b0;

        // Instruction fetch.
        if_req(32'h1000);
        run(8);
        check("if_ready_cyc", if_cyc, 6);
        check("if_inst", if_res, 32'h0000_0513);
        check("if_no_lsb_ready", n_lsb, 0);
        for (int k = 1; k <= 4; k++) check("if_mem_a", log_a[k], 32'h1000 + k - 1);

        // Byte / half loads with extension.
        lsb_req(1'b0, 3'b000, 32'h2001, 32'd0);
        run(5);
        check("lb_cyc", lsb_cyc[0], 3);
        check("lb_result", lsb_res[0], 32'hFFFF_FF80);
        lsb_req(1'b0, 3'b100, 32'h2001, 32'd0);
        run(5);
        check("lbu_result", lsb_res[0], 32'h0000_0080);
        lsb_req(1'b0, 3'b001, 32'h2000, 32'd0);
        run(6);
        check("lh_cyc", lsb_cyc[0], 4);
        check("lh_result", lsb_res[0], 32'hFFFF_8034);
        lsb_req(1'b0, 3'b101, 32'h2000, 32'd0);
        run(6);
        check("lhu_result", lsb_res[0], 32'h0000_8034);

        // Word store.
        lsb_req(1'b1, 3'b010, 32'h3000, 32'hDEAD_BEEF);
        run(7);
        check("sw_cyc", lsb_cyc[0], 5);
        check("sw_no_if_ready", if_cyc, 0);
        check("sw_nwr", nwr, 4);
        check("sw_a0", log_a[1], 32'h3000);
        check("sw_d0", {24'd0, log_dout[1]}, 32'hEF);
        check("sw_d1", {24'd0, log_dout[2]}, 32'hBE);
        check("sw_a3", log_a[4], 32'h3003);
        check("sw_d3", {24'd0, log_dout[4]}, 32'hDE);

        // Word load readback with one frozen cycle.
        rdy_low_at = 3;
        lsb_req(1'b0, 3'b010, 32'h3000, 32'd0);
        run(9);
        check("lw_freeze_cyc", lsb_cyc[0], 7);
        check("lw_freeze_result", lsb_res[0], 32'hDEAD_BEEF);

        // IO-region byte store stalled by a full buffer.
        io_lo = 1; io_hi = 3;
        lsb_req(1'b1, 3'b000, 32'h0003_0000, 32'h0000_005A);
        run(8);
        check("io_wr_c1", {31'd0, log_wr[1]}, 32'd0);
        check("io_wr_c3", {31'd0, log_wr[3]}, 32'd0);
        check("io_wr_c4", {31'd0, log_wr[4]}, 32'd1);
        check("io_a_c4", log_a[4], 32'h0003_0000);
        check("io_nwr", nwr, 1);
        check("io_cyc", lsb_cyc[0], 5);

        // Flush during a fetch.
        clr_at = 3;
        if_req(32'h1000);
        run(8);
        check("clr_if_no_ready", if_cyc, 0);
        check("clr_if_a3", log_a[3], 32'h1002);
        check("clr_if_idle_a4", log_a[4], 32'd0);

        // Flush during a word store.
        clr_at = 2;
        lsb_req(1'b1, 3'b010, 32'h3100, 32'h1122_3344);
        run(7);
        check("clr_sw_nwr", nwr, 4);
        check("clr_sw_no_ready", n_lsb, 0);
        check("clr_sw_d3", {24'd0, log_dout[4]}, 32'h11);

        // Ties: fresh reset so the round-robin last-grant starts at IF.
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        keep_lsb = 1'b1;
        @(negedge clk_in);
        lsb_valid = 1'b1; lsb_wr = 1'b0; lsb_len = 3'b010; lsb_addr = 32'h1000;
        if_valid  = 1'b1; if_addr = 32'h2000;
        run(20);
        check("tie_first_lsb_cyc", lsb_cyc[0], 6);
        check("tie_first_lsb_res", lsb_res[0], 32'h0000_0513);
`ifdef MEM_CTRL_RR_ARB_EN
        check("rr_if_cyc", if_cyc, 13);
        check("rr_if_inst", if_res, 32'h0000_8034);
        check("rr_second_lsb_cyc", lsb_cyc[1], 20);
        check("rr_n_lsb", n_lsb, 2);
`else
        check("fixed_second_lsb_cyc", lsb_cyc[1], 13);
        check("fixed_third_lsb_cyc", lsb_cyc[2], 20);
        check("fixed_if_starved", if_cyc, 0);
`endif

        // Reset in the middle of a store.
        lsb_req(1'b1, 3'b010, 32'h3200, 32'hCAFE_BABE);
        @(negedge clk_in);
        @(negedge clk_in);
        #1;
        check("mid_rst_pre_wr", {31'd0, mem_wr}, 32'd1);
        rst_in = 1'b1;
        #1;
        check("mid_rst_wr", {31'd0, mem_wr}, 32'd0);
        check("mid_rst_a", mem_a, 32'd0);
        lsb_valid = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        #1;
        check("post_rst_idle_a", mem_a, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
